// File: rtl/mult_div_unit_pkg.sv
// Shared encodings and helpers for the multiply/divide unit.
package mult_div_unit_pkg;

  localparam logic MDU_OP_MULT = 1'b0;
  localparam logic MDU_OP_DIV  = 1'b1;
  localparam int   MDU_ITER    = 32;

  typedef enum logic [1:0] {
    MDU_IDLE = 2'b00,
    MDU_RUN  = 2'b01,
    MDU_DONE = 2'b10
  } mdu_state_t;

  // Two's-complement negate when neg is set; also serves as abs() via the sign bit.
  function automatic logic [31:0] mdu_neg_if(input logic neg, input logic [31:0] v);
    return neg ? (~v + 32'd1) : v;
  endfunction

endpackage

// File: rtl/mult_div_unit_div_step.sv
// One restoring-division iteration on unsigned magnitudes: shift in a dividend bit,
// trial-subtract the divisor, keep the difference only if it did not go negative.
module mdu_div_step
  import mult_div_unit_pkg::*;
(
  input  logic [31:0] rem,
  input  logic        in_bit,
  input  logic [31:0] divisor,
  output logic [31:0] rem_next,
  output logic        q_bit
);

  logic [32:0] shifted;
  logic [32:0] diff;

  // rem < divisor holds between steps, so the shifted value always fits in 33 bits
  assign shifted  = {rem, in_bit};
  assign diff     = shifted - {1'b0, divisor};
  assign q_bit    = ~diff[32];
  assign rem_next = q_bit ? diff[31:0] : shifted[31:0];

endmodule

// File: rtl/mult_div_unit.sv
// Iterative signed MULT (radix-2 Booth) / DIV (restoring) unit, 32 iterations per op.
// Optional MDU_DIV0_EXCP_EN: DIV by zero finishes immediately with a div0 pulse.
module mult_div_unit
  import mult_div_unit_pkg::*;
(
  input  logic        clk,
  input  logic        reset_in,
  input  logic        start,
  input  logic        op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic        busy,
  output logic        done,
  output logic        div0
);

  mdu_state_t  state;
  logic [4:0]  cnt;
  logic        op_q;
  logic [32:0] acc;
  logic [31:0] qreg;
  logic        booth_bit;
  logic [31:0] opnd;
  logic        neg_quo;
  logic        neg_rem;
  logic        div_zero;

  logic [32:0] booth_sum;
  logic [32:0] acc_next;
  logic [31:0] q_mul_next;
  logic [31:0] rem_next;
  logic        q_bit;
  logic [31:0] res_hi;
  logic [31:0] res_lo;

  mdu_div_step u_div_step (
    .rem      (acc[31:0]),
    .in_bit   (qreg[31]),
    .divisor  (opnd),
    .rem_next (rem_next),
    .q_bit    (q_bit)
  );

  // Booth step: a 33-bit accumulator keeps -2^31 as multiplicand from overflowing
  always_comb begin
    booth_sum = acc;
    case ({qreg[0], booth_bit})
      2'b01:   booth_sum = acc + {opnd[31], opnd};
      2'b10:   booth_sum = acc - {opnd[31], opnd};
      default: booth_sum = acc;
    endcase
    acc_next   = {booth_sum[32], booth_sum[32:1]};
    q_mul_next = {booth_sum[0], qreg[31:1]};
  end

  always_comb begin
    res_hi = 32'd0;
    res_lo = 32'd0;
    if (op_q == MDU_OP_MULT) begin
      res_hi = acc_next[31:0];
      res_lo = q_mul_next;
    end else begin
      res_hi = mdu_neg_if(neg_rem, rem_next);
      res_lo = div_zero ? 32'hFFFF_FFFF : mdu_neg_if(neg_quo, {qreg[30:0], q_bit});
    end
  end

  always_ff @(posedge clk or negedge reset_in) begin
    if (!reset_in) begin
      state     <= MDU_IDLE;
      cnt       <= 5'd0;
      op_q      <= MDU_OP_MULT;
      acc       <= 33'd0;
      qreg      <= 32'd0;
      booth_bit <= 1'b0;
      opnd      <= 32'd0;
      neg_quo   <= 1'b0;
      neg_rem   <= 1'b0;
      div_zero  <= 1'b0;
      hi        <= 32'd0;
      lo        <= 32'd0;
      busy      <= 1'b0;
      done      <= 1'b0;
      div0      <= 1'b0;
    end else begin
      done <= 1'b0;
      div0 <= 1'b0;
      case (state)
        MDU_IDLE: begin
          if (start) begin
            op_q      <= op;
            cnt       <= 5'd0;
            acc       <= 33'd0;
            booth_bit <= 1'b0;
            neg_quo   <= a[31] ^ b[31];
            neg_rem   <= a[31];
            div_zero  <= (b == 32'd0);
            busy      <= 1'b1;
            if (op == MDU_OP_MULT) begin
              qreg <= b;
              opnd <= a;
            end else begin
              qreg <= mdu_neg_if(a[31], a);
              opnd <= mdu_neg_if(b[31], b);
            end
`ifdef MDU_DIV0_EXCP_EN
            if ((op == MDU_OP_DIV) && (b == 32'd0)) begin
              state <= MDU_DONE;
              done  <= 1'b1;
              div0  <= 1'b1;
            end else begin
              state <= MDU_RUN;
            end
`else
            state <= MDU_RUN;
`endif
          end
        end
        MDU_RUN: begin
          cnt <= cnt + 5'd1;
          if (op_q == MDU_OP_MULT) begin
            acc       <= acc_next;
            qreg      <= q_mul_next;
            booth_bit <= qreg[0];
          end else begin
            acc  <= {1'b0, rem_next};
            qreg <= {qreg[30:0], q_bit};
          end
          if (cnt == 5'(MDU_ITER - 1)) begin
            state <= MDU_DONE;
            done  <= 1'b1;
            hi    <= res_hi;
            lo    <= res_lo;
          end
        end
        MDU_DONE: begin
          state <= MDU_IDLE;
          busy  <= 1'b0;
        end
        default: begin
          state <= MDU_IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mult_div_unit.sv
// Scoreboard bench for mult_div_unit: directed vectors, monitor checks on every done pulse.
module tb_mult_div_unit;
  import mult_div_unit_pkg::*;

  logic        clk = 1'b0;
  logic        reset_in;
  logic        start;
  logic        op;
  logic [31:0] a;
  logic [31:0] b;
  logic [31:0] hi;
  logic [31:0] lo;
  logic        busy;
  logic        done;
  logic        div0;

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
    logic        div0;
    int          cyc;
  } exp_t;

  exp_t sb[$];
  exp_t e_mon;
  int   checks = 0;
  int   passes = 0;
  int   cyc    = 0;

  mult_div_unit dut (
    .clk      (clk),
    .reset_in (reset_in),
    .start    (start),
    .op       (op),
    .a        (a),
    .b        (b),
    .hi       (hi),
    .lo       (lo),
    .busy     (busy),
    .done     (done),
    .div0     (div0)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc++;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
  endtask

  // Monitor: every done pulse pops one expected result
  always @(negedge clk) begin
    if (reset_in === 1'b1 && done === 1'b1) begin
      if (sb.size() == 0) begin
        chk("unexpected_done", {31'd0, done}, 32'd0);
      end else begin
        e_mon = sb.pop_front();
        chk("hi", hi, e_mon.hi);
        chk("lo", lo, e_mon.lo);
        chk("div0", {31'd0, div0}, {31'd0, e_mon.div0});
        chk("done_cycle", cyc, e_mon.cyc);
      end
    end
  end

  // Called at a falling edge; the next rising edge accepts the operation
  task automatic issue(input logic o, input logic [31:0] x, input logic [31:0] y,
                       input logic [31:0] eh, input logic [31:0] el, input logic ed,
                       input int lat, input bit track);
    op    = o;
    a     = x;
    b     = y;
    start = 1'b1;
    if (track) sb.push_back('{eh, el, ed, cyc + lat});
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done(input bit poke);
    int n = 0;
    while (done !== 1'b1 && n < 40) begin
      @(negedge clk);
      n++;
    end
    chk("done_seen", {31'd0, done}, 32'd1);
    if (poke) begin
      start = 1'b1;
      op    = MDU_OP_MULT;
      a     = 32'd3;
      b     = 32'd3;
    end
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic run(input logic o, input logic [31:0] x, input logic [31:0] y,
                     input logic [31:0] eh, input logic [31:0] el, input logic ed, input int lat);
    issue(o, x, y, eh, el, ed, lat, 1'b1);
    wait_done(1'b0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset_in = 1'b0;
    start    = 1'b0;
    op       = MDU_OP_MULT;
    a        = 32'd0;
    b        = 32'd0;
    repeat (3) @(negedge clk);
    chk("rst_hi", hi, 32'd0);
    chk("rst_lo", lo, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_div0", {31'd0, div0}, 32'd0);

    // Start accepted on the first edge after reset release
    reset_in = 1'b1;
    run(MDU_OP_MULT, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'hFFFF_FFEB, 1'b0, 33);
    repeat (5) @(negedge clk);
    chk("hold_hi", hi, 32'hFFFF_FFFF);
    chk("hold_lo", lo, 32'hFFFF_FFEB);

    // Start during the DONE cycle must be ignored
    issue(MDU_OP_MULT, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000, 1'b0, 33, 1'b1);
    wait_done(1'b1);
    chk("done_start_busy0", {31'd0, busy}, 32'd0);
    @(negedge clk);
    chk("done_start_busy1", {31'd0, busy}, 32'd0);
    chk("done_start_hi", hi, 32'h4000_0000);

    run(MDU_OP_DIV, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0, 33);
    run(MDU_OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000, 1'b0, 33);
`ifdef MDU_DIV0_EXCP_EN
    run(MDU_OP_DIV, 32'd5, 32'd0, 32'h0000_0000, 32'h8000_0000, 1'b1, 1);
`else
    run(MDU_OP_DIV, 32'd5, 32'd0, 32'h0000_0005, 32'hFFFF_FFFF, 1'b0, 33);
`endif
    run(MDU_OP_MULT, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, 32'h0000_0001, 1'b0, 33);
    run(MDU_OP_MULT, 32'h7FFF_FFFF, 32'h7FFF_FFFF, 32'h3FFF_FFFF, 32'h0000_0001, 1'b0, 33);
    run(MDU_OP_DIV, 32'd100, 32'd7, 32'h0000_0002, 32'h0000_000E, 1'b0, 33);
    run(MDU_OP_DIV, 32'd7, 32'hFFFF_FFFE, 32'h0000_0001, 32'hFFFF_FFFD, 1'b0, 33);
    run(MDU_OP_DIV, 32'hFFFF_FF9C, 32'hFFFF_FFF9, 32'hFFFF_FFFE, 32'h0000_000E, 1'b0, 33);
    run(MDU_OP_MULT, 32'h0001_0000, 32'h0001_0000, 32'h0000_0001, 32'h0000_0000, 1'b0, 33);

    // Second start while busy must not re-latch operands
    issue(MDU_OP_MULT, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'hFFFF_FFEB, 1'b0, 33, 1'b1);
    repeat (9) @(negedge clk);
    start = 1'b1;
    op    = MDU_OP_DIV;
    a     = 32'd100;
    b     = 32'd7;
    @(negedge clk);
    start = 1'b0;
    wait_done(1'b0);

    // Reset mid-RUN discards the operation
    issue(MDU_OP_MULT, 32'd5, 32'd6, 32'd0, 32'd0, 1'b0, 33, 1'b0);
    repeat (19) @(negedge clk);
    reset_in = 1'b0;
    #1;
    chk("abort_hi", hi, 32'd0);
    chk("abort_lo", lo, 32'd0);
    chk("abort_busy", {31'd0, busy}, 32'd0);
    chk("abort_done", {31'd0, done}, 32'd0);
    chk("abort_div0", {31'd0, div0}, 32'd0);
    repeat (3) @(negedge clk);
    chk("abort_busy_hold", {31'd0, busy}, 32'd0);
    reset_in = 1'b1;
    run(MDU_OP_DIV, 32'd100, 32'd7, 32'h0000_0002, 32'h0000_000E, 1'b0, 33);
    repeat (40) @(negedge clk);
    chk("sb_empty", sb.size(), 32'd0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
